// File: rtl/sha2_sched_pkg.sv
// Shared SHA-2 message-schedule definitions: sigma rotate/shift amounts, FSM states,
// and width-generic rotate/sigma helpers (words up to 64 bits, zero-extended).
package sha2_sched_pkg;

  localparam int SIG0_R1_256 = 7;
  localparam int SIG0_R2_256 = 18;
  localparam int SIG0_S_256  = 3;
  localparam int SIG1_R1_256 = 17;
  localparam int SIG1_R2_256 = 19;
  localparam int SIG1_S_256  = 10;

  localparam int SIG0_R1_512 = 1;
  localparam int SIG0_R2_512 = 8;
  localparam int SIG0_S_512  = 7;
  localparam int SIG1_R1_512 = 19;
  localparam int SIG1_R2_512 = 61;
  localparam int SIG1_S_512  = 6;

  typedef enum logic {IDLE, STREAM} state_t;

  // 32-bit words live in the low half with the upper half held at zero.
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    logic [63:0] r;
    if (w == 32) r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    else         r = (x >> n) | (x << (64 - n));
    return r;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    logic [63:0] r;
    if (w == 32) r = rotr(x, SIG0_R1_256, 32) ^ rotr(x, SIG0_R2_256, 32) ^ (x >> SIG0_S_256);
    else         r = rotr(x, SIG0_R1_512, 64) ^ rotr(x, SIG0_R2_512, 64) ^ (x >> SIG0_S_512);
    return r;
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    logic [63:0] r;
    if (w == 32) r = rotr(x, SIG1_R1_256, 32) ^ rotr(x, SIG1_R2_256, 32) ^ (x >> SIG1_S_256);
    else         r = rotr(x, SIG1_R1_512, 64) ^ rotr(x, SIG1_R2_512, 64) ^ (x >> SIG1_S_512);
    return r;
  endfunction

endpackage

// File: rtl/sha2_sigma.sv
// Combinational SHA-2 small sigma (sig0 when UPPER=0, sig1 when UPPER=1) for one word.
// Zero latency; no flow control.
module sha2_sigma
  import sha2_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter bit UPPER  = 1'b0
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] y
);

  logic [63:0] xe;

  assign xe = 64'(x);
  assign y  = WORD_W'(UPPER ? sig1(xe, WORD_W) : sig0(xe, WORD_W));

endmodule

// File: rtl/w_schedule_stream.sv
// SHA-2 message schedule streamer: loads a 16-word block, emits W[0..ROUNDS-1] one per cycle.
// Optional WSCHED_REG_OUT_EN registers the output stage (W[0] one cycle later, same throughput).
module w_schedule_stream
  import sha2_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  localparam int IW    = $clog2(ROUNDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 abort,
  input  logic                 block_valid,
  output logic                 block_ready,
  input  logic [16*WORD_W-1:0] block_data,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_word,
  output logic [IW-1:0]        w_index,
  output logic                 w_last,
  output logic                 busy
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] win [16];
  logic [WORD_W-1:0] s0, s1, new_word;
  logic [IW-1:0]     t;
  logic              accept, advance, adv_rdy, at_last, out_empty;

  sha2_sigma #(.WORD_W(WORD_W), .UPPER(1'b0)) u_sig0 (.x(win[1]),  .y(s0));
  sha2_sigma #(.WORD_W(WORD_W), .UPPER(1'b1)) u_sig1 (.x(win[14]), .y(s1));

  assign new_word = s1 + win[9] + s0 + win[0];
  assign at_last  = (t == IW'(ROUNDS - 1));
  assign busy     = (state != IDLE);

`ifdef WSCHED_REG_OUT_EN
  logic              reg_vld, reg_last;
  logic [WORD_W-1:0] reg_word;
  logic [IW-1:0]     reg_idx;

  // The window advances whenever the output register is empty or being consumed.
  assign adv_rdy   = !reg_vld || w_ready;
  assign out_empty = !reg_vld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      reg_vld  <= 1'b0;
      reg_last <= 1'b0;
      reg_word <= '0;
      reg_idx  <= '0;
    end else if (abort) begin
      reg_vld  <= 1'b0;
    end else if (advance) begin
      reg_vld  <= 1'b1;
      reg_word <= win[0];
      reg_idx  <= t;
      reg_last <= at_last;
    end else if (w_ready) begin
      reg_vld  <= 1'b0;
    end
  end

  assign w_valid = reg_vld;
  assign w_word  = reg_vld ? reg_word : '0;
  assign w_index = reg_vld ? reg_idx  : '0;
  assign w_last  = reg_vld && reg_last;
`else
  assign adv_rdy   = w_ready;
  assign out_empty = 1'b1;
  assign w_valid   = (state == STREAM);
  assign w_word    = (state == STREAM) ? win[0] : '0;
  assign w_index   = (state == STREAM) ? t : '0;
  assign w_last    = (state == STREAM) && at_last;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    block_ready = 1'b0;
    accept      = 1'b0;
    advance     = 1'b0;
    case (state)
      IDLE: begin
        block_ready = out_empty && !reset;
        accept      = block_valid && block_ready && !abort;
        if (accept) state_nxt = STREAM;
      end
      STREAM: begin
        advance = adv_rdy && !abort;
        if (abort || (advance && at_last)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Window entry 0 is always the word currently offered; entry 15 the newest computed word.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      t <= '0;
    end else if (abort) begin
      t <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) win[i] <= block_data[(15-i)*WORD_W +: WORD_W];
      t <= '0;
    end else if (advance) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= new_word;
      t       <= at_last ? '0 : t + 1'b1;
    end
  end

endmodule

// File: tb/tb_w_schedule_stream.sv
// Directed bench: SHA-256 and SHA-512 "abc" schedules, backpressure, abort and async reset.
module tb_w_schedule_stream;

`ifdef WSCHED_REG_OUT_EN
  localparam int REG_LAT = 1;
`else
  localparam int REG_LAT = 0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         abort = 1'b0;
  logic         bv = 1'b0;
  logic         ready = 1'b0;
  bit           sel = 1'b0;
  logic [511:0] a_data = '0;
  logic [1023:0] b_data = '0;

  logic        a_bv, a_abort, a_brdy, a_valid, a_last, a_busy;
  logic [31:0] a_word;
  logic [5:0]  a_index;
  logic        b_bv, b_abort, b_brdy, b_valid, b_last, b_busy;
  logic [63:0] b_word;
  logic [6:0]  b_index;

  logic        cur_valid, cur_last, cur_busy, cur_brdy;
  logic [63:0] cur_word, cur_index;

  int checks = 0;
  int errors = 0;
  logic [63:0] blk   [16];
  logic [63:0] ref_w [128];
  logic [63:0] got_a [128];
  logic [63:0] got_b [128];

  typedef struct {
    bit          s;
    int          idx;
    logic [63:0] word;
  } vec_t;
  vec_t vecs [8];

  assign a_bv    = bv & ~sel;
  assign b_bv    = bv & sel;
  assign a_abort = abort & ~sel;
  assign b_abort = abort & sel;

  assign cur_valid = sel ? b_valid : a_valid;
  assign cur_last  = sel ? b_last  : a_last;
  assign cur_busy  = sel ? b_busy  : a_busy;
  assign cur_brdy  = sel ? b_brdy  : a_brdy;
  assign cur_word  = sel ? b_word  : {32'h0, a_word};
  assign cur_index = sel ? 64'(b_index) : 64'(a_index);

  w_schedule_stream #(.WORD_W(32), .ROUNDS(64)) dut_a (
    .clock(clock), .reset(reset), .abort(a_abort),
    .block_valid(a_bv), .block_ready(a_brdy), .block_data(a_data),
    .w_valid(a_valid), .w_ready(ready), .w_word(a_word), .w_index(a_index),
    .w_last(a_last), .busy(a_busy)
  );

  w_schedule_stream #(.WORD_W(64), .ROUNDS(80)) dut_b (
    .clock(clock), .reset(reset), .abort(b_abort),
    .block_valid(b_bv), .block_ready(b_brdy), .block_data(b_data),
    .w_valid(b_valid), .w_ready(ready), .w_word(b_word), .w_index(b_index),
    .w_last(b_last), .busy(b_busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ror(input logic [63:0] x, input int n, input int wb);
    logic [63:0]  d32;
    logic [127:0] d64;
    d32 = {x[31:0], x[31:0]};
    d64 = {x, x};
    if (wb == 32) return {32'h0, d32[n +: 32]};
    return d64[n +: 64];
  endfunction

  function automatic logic [63:0] s0m(input logic [63:0] x, input int wb);
    if (wb == 32) return ror(x, 7, 32) ^ ror(x, 18, 32) ^ (x >> 3);
    return ror(x, 1, 64) ^ ror(x, 8, 64) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] s1m(input logic [63:0] x, input int wb);
    if (wb == 32) return ror(x, 17, 32) ^ ror(x, 19, 32) ^ (x >> 10);
    return ror(x, 19, 64) ^ ror(x, 61, 64) ^ (x >> 6);
  endfunction

  task automatic build_ref(input int wb, input int rounds);
    logic [63:0] m;
    m = (wb == 32) ? 64'h0000_0000_FFFF_FFFF : '1;
    for (int i = 0; i < 16; i++) begin
      ref_w[i] = blk[i] & m;
      a_data[(15-i)*32 +: 32] = blk[i][31:0];
      b_data[(15-i)*64 +: 64] = blk[i];
    end
    for (int i = 16; i < rounds; i++)
      ref_w[i] = (s1m(ref_w[i-2], wb) + ref_w[i-7] + s0m(ref_w[i-15], wb) + ref_w[i-16]) & m;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle after acceptance.
  task automatic send(input bit s);
    int w = 0;
    sel = s;
    bv  = 1'b1;
    while (!cur_brdy && w < 50) begin
      @(negedge clock);
      w++;
    end
    chk("send_ready_seen", 64'(cur_brdy), 64'(1));
    @(negedge clock);
    bv = 1'b0;
    chk("first_cycle_valid", 64'(cur_valid), 64'(REG_LAT == 0));
    chk("busy_after_accept", 64'(cur_busy), 64'(1));
    chk("brdy_after_accept", 64'(cur_brdy), 64'(0));
  endtask

  task automatic stream(input int rounds, input bit rnd, input int abort_at, input bit timing);
    int n = 0;
    int c = 1;
    bit stalled = 1'b0;
    logic [63:0] pw = '0;
    while (n < rounds) begin
      if (c > 4000) begin
        chk("stream_timeout", 64'(n), 64'(rounds));
        return;
      end
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!cur_valid) begin
        chk("last_without_valid", 64'(cur_last), 64'(0));
      end else begin
        if (stalled) chk("stall_hold_word", cur_word, pw);
        chk("w_index", cur_index, 64'(n));
        chk("w_word", cur_word, ref_w[n]);
        chk("w_last", 64'(cur_last), 64'(n == rounds - 1));
        if (sel) got_b[n] = cur_word;
        else     got_a[n] = cur_word;
        if (abort_at == n) begin
          abort = 1'b1;
          @(negedge clock);
          abort = 1'b0;
          chk("abort_valid", 64'(cur_valid), 64'(0));
          chk("abort_busy", 64'(cur_busy), 64'(0));
          chk("abort_brdy", 64'(cur_brdy), 64'(1));
          chk("abort_index", cur_index, 64'(0));
          return;
        end
        if (ready) begin
          if (timing && n == rounds - 1) chk("last_word_cycle", 64'(c), 64'(rounds + REG_LAT));
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          pw = cur_word;
        end
      end
      @(negedge clock);
      c++;
    end
    chk("end_brdy", 64'(cur_brdy), 64'(1));
    chk("end_valid", 64'(cur_valid), 64'(0));
    chk("end_busy", 64'(cur_busy), 64'(0));
  endtask

  initial begin
    vecs[0] = '{1'b0,  0, 64'h0000_0000_6162_6380};
    vecs[1] = '{1'b0, 15, 64'h0000_0000_0000_0018};
    vecs[2] = '{1'b0, 16, 64'h0000_0000_6162_6380};
    vecs[3] = '{1'b0, 17, 64'h0000_0000_000F_0000};
    vecs[4] = '{1'b0, 63, 64'h0000_0000_12B1_EDEB};
    vecs[5] = '{1'b1,  0, 64'h6162_6380_0000_0000};
    vecs[6] = '{1'b1, 16, 64'h6162_6380_0000_0000};
    vecs[7] = '{1'b1, 17, 64'h0003_0000_0000_00C0};
    for (int i = 0; i < 128; i++) begin
      got_a[i] = '0;
      got_b[i] = '0;
    end

    repeat (2) @(negedge clock);
    chk("rst_valid", 64'(a_valid), 64'(0));
    chk("rst_word", 64'(a_word), 64'(0));
    chk("rst_index", 64'(a_index), 64'(0));
    chk("rst_last", 64'(a_last), 64'(0));
    chk("rst_busy", 64'(a_busy), 64'(0));
    reset = 1'b0;
    #1;
    chk("brdy_after_reset", 64'(a_brdy), 64'(1));
    @(negedge clock);

    // SHA-256 "abc", consumer always ready
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 64'h6162_6380;
    blk[15] = 64'h18;
    build_ref(32, 64);
    send(1'b0);
    stream(64, 1'b0, -1, 1'b1);

    // same block, random backpressure
    send(1'b0);
    stream(64, 1'b1, -1, 1'b0);

    // abort at index 20, then abort while idle, then a clean restart
    send(1'b0);
    stream(64, 1'b0, 20, 1'b0);
    bv    = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    chk("idle_abort_not_accepted", 64'(a_busy), 64'(0));
    chk("idle_abort_valid", 64'(a_valid), 64'(0));
    bv    = 1'b0;
    abort = 1'b0;
    send(1'b0);
    stream(64, 1'b0, -1, 1'b0);

    // async reset between edges mid-stream, block_valid held across it
    send(1'b0);
    ready = 1'b1;
    repeat (5) @(negedge clock);
    bv = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(a_valid), 64'(0));
    chk("async_rst_busy", 64'(a_busy), 64'(0));
    chk("async_rst_word", 64'(a_word), 64'(0));
    chk("async_rst_index", 64'(a_index), 64'(0));
    chk("async_rst_last", 64'(a_last), 64'(0));
    @(negedge clock);
    chk("no_accept_in_reset", 64'(a_busy), 64'(0));
    reset = 1'b0;
    @(negedge clock);
    chk("accept_after_reset", 64'(a_busy), 64'(1));
    bv = 1'b0;
    stream(64, 1'b0, -1, 1'b0);

    // SHA-512 "abc"
    for (int i = 0; i < 16; i++) blk[i] = '0;
    blk[0]  = 64'h6162_6380_0000_0000;
    blk[15] = 64'h18;
    build_ref(64, 80);
    send(1'b1);
    stream(80, 1'b0, -1, 1'b1);

    for (int i = 0; i < 8; i++)
      chk($sformatf("known_w%0d_%s", vecs[i].idx, vecs[i].s ? "512" : "256"),
          vecs[i].s ? got_b[vecs[i].idx] : got_a[vecs[i].idx], vecs[i].word);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/w_schedule_stream.md
Name: w_schedule_stream

Overview:
Parametrised SHA-2 message-schedule generator, successor to the fixed SHA-256 w64 expander.
- Accepts one 16-word message block and streams W[0..ROUNDS-1] one word per cycle over a valid/ready handshake to the compression round engine.
- Uses a 16-entry sliding window instead of a full 64-word vector.
- Supports SHA-256 (32-bit words, 64 rounds) and SHA-512 (64-bit words, 80 rounds).

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-256 sigma set) or 64 (SHA-512 sigma set).
ROUNDS, 64, schedule words emitted per block; 64 for WORD_W=32, 80 for WORD_W=64; 17..127 legal.

Ports:
clock  in  1  clock.
reset  in  1  asynchronous, active-high reset.
abort  in  1  synchronous flush; returns block to IDLE.
block_valid  in  1  message block offered.
block_ready  out  1  block can be accepted.
block_data  in  16*WORD_W  message block; W[0] = block_data[16*WORD_W-1 -: WORD_W] (big-endian word order).
w_valid  out  1  w_word valid.
w_ready  in  1  consumer accepts w_word.
w_word  out  WORD_W  current schedule word W[t].
w_index  out  $clog2(ROUNDS)  t of current word.
w_last  out  1  high when w_index == ROUNDS-1.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, active-high) clears to: state IDLE; window all 0; t=0; w_valid=0; w_word=0; w_index=0; w_last=0; busy=0. block_ready is 1 once reset deasserts.
- States:
  - IDLE: block_ready=1, w_valid=0. On block_valid&&block_ready, load window[i]=W[i] for i=0..15, set t=0, go to STREAM.
  - STREAM: block_ready=0, w_valid=1, w_word=window[0], w_index=t.
    - On w_valid&&w_ready: window shifts down one entry; window[15] takes new word; t increments.
    - If t==ROUNDS-1 on that handshake, go to IDLE.
- Next-word rule: new = sig1(window[14]) + window[9] + sig0(window[1]) + window[0], mod 2^WORD_W.
  - WORD_W=32: sig0 = ROTR7^ROTR18^SHR3; sig1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: sig0 = ROTR1^ROTR8^SHR7; sig1 = ROTR19^ROTR61^SHR6.
  - Words computed past ROUNDS are discarded.
- Latency and throughput:
  - Block accepted at edge k: w_valid high after edge k, W[0] presented in cycle k+1.
  - With w_ready held high: one word per cycle; final word in cycle k+ROUNDS.
  - block_ready rises in the cycle after the last handshake (no back-to-back overlap).
- Backpressure: while w_ready=0, w_word, w_index, w_last and the window all hold.
- abort: highest priority over every handshake. Next state is IDLE with w_valid=0 and t=0; window contents are don't-care. abort in IDLE has no effect; a block offered in the same cycle is not accepted.
- reset mid-stream: immediate return to reset values; partial stream lost; no w_last emitted.
- w_last valid only when w_valid=1; otherwise 0.

Optional Feature:
WSCHED_REG_OUT_EN
- Defined: w_valid/w_word/w_index/w_last come from a one-entry ready-aware pipeline register.
  - W[0] appears in cycle k+2.
  - Still one word per cycle when w_ready is held high.
  - Register stalls correctly under backpressure, no word dropped or duplicated.
  - abort and reset also clear the register.
  - block_ready rises only after the register has drained its last word.
- Undefined: outputs combinational from window[0]/t as above; latency k+1.

Decomposition:
- Package sha2_sched_pkg:
  - WORD_W-indexed rotate/shift constants (SIG0_R1, SIG0_R2, SIG0_S, SIG1_R1, SIG1_R2, SIG1_S for 256 and 512).
  - state enum {IDLE, STREAM}.
  - Functions rotr and sig0/sig1 parametrised by width.
- One sub-module, sha2_sigma: combinational sig0/sig1 with a WORD_W parameter, instantiated twice.
- Window shift register, counter and FSM stay in the top module.

Test Plan:
- SHA-256 "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), w_ready=1 → W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB. Exactly 64 words; w_last only with w_index=63; block_ready=1 the cycle after.
- WORD_W=64, ROUNDS=80, SHA-512 "abc" (W0=0x6162638000000000, W15=0x18) → W16=0x6162638000000000; 80 words; w_last at w_index=79.
- Backpressure: toggle w_ready pseudo-randomly (50%) on the "abc" block → identical 64-word sequence to the w_ready=1 run, and w_word stable while stalled.
- abort asserted at w_index=20 → next cycle w_valid=0, busy=0, block_ready=1. A new block then restarts at w_index=0 with correct W values.
- Async reset pulsed mid-stream, between clock edges → outputs reach reset values immediately, without waiting for a clock edge; block_valid held high during reset is not accepted until reset deasserts.
- With WSCHED_REG_OUT_EN defined → same sequences as above, with first w_valid one cycle later.
